jt12_write_seq: RTL and testbench

JT12_WRITE_SEQ -- requirements
Module: jt12_write_seq

---
 rtl/jt12_pkg.sv | 27 ++
 rtl/jt12_cmd_fifo.sv | 52 +++++
 rtl/jt12_write_seq.sv | 148 ++++++++++++++
 tb/tb_jt12_write_seq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_pkg.sv
// jt12_pkg -- shared types and constants for the JT12 register write sequencer. rev 1.0
`default_nettype none

package jt12_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_AGUARD = 3'd2,
    ST_AWAIT  = 3'd3,
    ST_DATA   = 3'd4,
    ST_DGUARD = 3'd5,
    ST_DWAIT  = 3'd6
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CMD_W           = 17;

  typedef struct packed {
    logic       port;
    logic [7:0] regn;
    logic [7:0] data;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/jt12_cmd_fifo.sv
// jt12_cmd_fifo -- power-of-two command FIFO with a combinational head output. rev 1.0
`default_nettype none

module jt12_cmd_fifo
  import jt12_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/jt12_write_seq.sv
// jt12_write_seq -- queues YM register writes and sequences address/data strobes against busy. rev 1.0
`default_nettype none

module jt12_write_seq
  import jt12_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_port,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       write,
  output logic [1:0] addr,
  output logic [7:0] dout,
  input  logic       busy,
  output logic       idle,
  output logic       timeout_err
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state;
  state_t      state_nx;
  cmd_t        head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        cache_valid;
  logic        cache_port;
  logic [7:0]  cache_reg;
  logic        hit;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        expire;
  logic        write_nx;
  logic [1:0]  addr_nx;
  logic [7:0]  dout_nx;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign idle      = fifo_empty && (state == ST_IDLE);
  assign hit       = cache_valid && (cache_port == head.port) && (cache_reg == head.regn);
  assign wait_inc  = wait_cnt + 16'd1;

  jt12_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({cmd_port, cmd_reg, cmd_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    expire   = 1'b0;
    write_nx = 1'b0;
    addr_nx  = addr;
    dout_nx  = dout;
    case (state)
      ST_IDLE:   if (!fifo_empty && !busy) state_nx = hit ? ST_DATA : ST_ADDR;
      ST_ADDR:   state_nx = ST_AGUARD;
      ST_AGUARD: state_nx = ST_AWAIT;
      ST_AWAIT: begin
        if (!busy) begin
          state_nx = ST_DATA;
        end else if (wait_inc == TIMEOUT_CNT) begin
          expire   = 1'b1;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        pop      = 1'b1;
        state_nx = ST_DGUARD;
      end
      ST_DGUARD: state_nx = ST_DWAIT;
      ST_DWAIT: begin
        if (!busy) begin
          state_nx = ST_IDLE;
        end else if (wait_inc == TIMEOUT_CNT) begin
          expire   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Strobe outputs are registered so they line up with the ADDR/DATA state cycle.
    if (state_nx == ST_ADDR) begin
      write_nx = 1'b1;
      addr_nx  = {head.port, 1'b0};
      dout_nx  = head.regn;
    end else if (state_nx == ST_DATA) begin
      write_nx = 1'b1;
      addr_nx  = {head.port, 1'b1};
      dout_nx  = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      write       <= 1'b0;
      addr        <= 2'd0;
      dout        <= 8'd0;
      cache_valid <= 1'b0;
      cache_port  <= 1'b0;
      cache_reg   <= 8'd0;
      wait_cnt    <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      write <= write_nx;
      addr  <= addr_nx;
      dout  <= dout_nx;
      if (state == ST_ADDR) begin
        cache_valid <= 1'b1;
        cache_port  <= head.port;
        cache_reg   <= head.regn;
      end
      // A timeout leaves the chip state unknown, so the next write re-sends its address.
      if (expire) begin
        cache_valid <= 1'b0;
        timeout_err <= 1'b1;
      end
      if (state == ST_AGUARD || state == ST_DGUARD) begin
        wait_cnt <= 16'd0;
      end else if ((state == ST_AWAIT || state == ST_DWAIT) && busy) begin
        wait_cnt <= wait_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jt12_write_seq.sv
// tb_jt12_write_seq -- scenario bench with a busy-receiver model and an expected-strobe model. rev 1.0
`default_nettype none

module tb_jt12_write_seq;

  localparam int DEPTH = 4;
  localparam int TO    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_port = 1'b0;
  logic [7:0] cmd_reg = 8'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       busy = 1'b0;
  logic       cmd_ready;
  logic       write;
  logic [1:0] addr;
  logic [7:0] dout;
  logic       idle;
  logic       timeout_err;

  always #5 clk = ~clk;

  jt12_write_seq #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .rst         (rst),
    .clk         (clk),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_port    (cmd_port),
    .cmd_reg     (cmd_reg),
    .cmd_data    (cmd_data),
    .write       (write),
    .addr        (addr),
    .dout        (dout),
    .busy        (busy),
    .idle        (idle),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    int         t;
    logic       b;
  } strobe_t;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } exp_t;

  strobe_t got_q[$];
  exp_t    exp_q[$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;

  // Receiver model: busy rises with each write strobe and stays high for a number of cycles.
  int   rx_cnt = 0;
  int   rx_len = 2;
  logic rx_force = 1'b0;
  logic rx_force_val = 1'b0;
  logic rx_rand = 1'b0;

  // Reference model: address cache as described by the write rules.
  logic       m_valid = 1'b0;
  logic       m_port = 1'b0;
  logic [7:0] m_reg = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write) got_q.push_back('{addr, dout, cyc, busy});
    if (rx_force) begin
      busy = rx_force_val;
    end else begin
      if (write) rx_cnt = rx_rand ? int'($urandom_range(6, 1)) : rx_len;
      else if (rx_cnt > 0) rx_cnt--;
      busy = (rx_cnt > 0);
    end
  end

  task automatic model_cmd(input logic p, input logic [7:0] r, input logic [7:0] d);
    if (!(m_valid && m_port == p && m_reg == r)) begin
      exp_q.push_back('{{p, 1'b0}, r});
      m_valid = 1'b1;
      m_port  = p;
      m_reg   = r;
    end
    exp_q.push_back('{{p, 1'b1}, d});
  endtask

  task automatic send(input logic p, input logic [7:0] r, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_port  = p;
    cmd_reg   = r;
    cmd_data  = d;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL send_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end else begin
      model_cmd(p, r, d);
      @(posedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL wait_idle: idle=%b after %0d cycles, required 1", idle, n);
    end
  endtask

  task automatic compare(input int start, input string name, input bit chk_busy);
    int n = got_q.size() - start;
    checks++;
    if (n != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: strobes=%0d required %0d", name, n, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (got_q[start+i].a !== exp_q[i].a || got_q[start+i].d !== exp_q[i].d) begin
        failures++;
        $display("FAIL %s_strobe%0d: addr=%0d dout=%02h required addr=%0d dout=%02h",
                 name, i, got_q[start+i].a, got_q[start+i].d, exp_q[i].a, exp_q[i].d);
      end
      if (chk_busy) begin
        checks++;
        if (got_q[start+i].b !== 1'b0) begin
          failures++;
          $display("FAIL %s_busy%0d: busy at strobe=%b required 0", name, i, got_q[start+i].b);
        end
      end
      if (i > 0) begin
        checks++;
        if (got_q[start+i].t - got_q[start+i-1].t < 2) begin
          failures++;
          $display("FAIL %s_spacing%0d: gap=%0d required >=2", name, i,
                   got_q[start+i].t - got_q[start+i-1].t);
        end
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      if (addr !== exp_q[exp_q.size()-1].a || dout !== exp_q[exp_q.size()-1].d || write !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold: addr=%0d dout=%02h write=%b required addr=%0d dout=%02h write=0",
                 name, addr, dout, write, exp_q[exp_q.size()-1].a, exp_q[exp_q.size()-1].d);
      end
    end
    exp_q.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    m_valid   = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (write !== 1'b0 || addr !== 2'd0 || dout !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: write=%b addr=%0d dout=%02h required 0/0/00", write, addr, dout);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_timeout_err: got %b required 0", timeout_err);
    end
    checks++;
    if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_idle: cmd_ready=%b idle=%b required 1/1", cmd_ready, idle);
    end
  endtask

  task automatic test_single();
    int start = got_q.size();
    rx_len = 2;
    send(1'b0, 8'h28, 8'hF0);
    wait_idle(200);
    checks++;
    if (got_q.size() < start + 2 || got_q[start+1].t - got_q[start].t != 3) begin
      failures++;
      $display("FAIL single_latency: strobes=%0d (gap not 3) required 2 strobes 3 cycles apart",
               got_q.size() - start);
    end
    compare(start, "single", 1'b1);
  endtask

  task automatic test_cache_hit();
    int start = got_q.size();
    send(1'b0, 8'h2A, 8'h80);
    send(1'b0, 8'h2A, 8'h81);
    wait_idle(200);
    checks++;
    if (got_q.size() - start != 3) begin
      failures++;
      $display("FAIL hit_total: strobes=%0d required 3", got_q.size() - start);
    end
    compare(start, "hit", 1'b1);
  endtask

  task automatic test_port_differs();
    int start = got_q.size();
    send(1'b1, 8'hA4, 8'h22);
    send(1'b0, 8'hA4, 8'h22);
    wait_idle(200);
    checks++;
    if (got_q.size() < start + 3 || got_q[start+2].a !== 2'b00) begin
      failures++;
      $display("FAIL port_addr: third strobe missing or addr not 0 (strobes=%0d)", got_q.size() - start);
    end
    compare(start, "port", 1'b1);
  endtask

  task automatic test_fifo_full();
    int   start = got_q.size();
    logic seen_ready = 1'b0;
    rx_force_val = 1'b1;
    rx_force     = 1'b1;
    @(negedge clk);
    send(1'b0, 8'h40, 8'($urandom));
    send(1'b1, 8'h41, 8'($urandom));
    send(1'b1, 8'h41, 8'($urandom));
    send(1'b0, 8'h42, 8'($urandom));
    checks++;
    if (cmd_ready !== 1'b0 || idle !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: cmd_ready=%b idle=%b required 0/0", cmd_ready, idle);
    end
    cmd_valid = 1'b1;
    cmd_port  = 1'b0;
    cmd_reg   = 8'h42;
    cmd_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_ready) seen_ready = 1'b1;
    end
    checks++;
    if (seen_ready || got_q.size() != start) begin
      failures++;
      $display("FAIL full_holdoff: ready_seen=%b strobes=%0d required 0/0", seen_ready, got_q.size() - start);
    end
    rx_force = 1'b0;
    send(1'b0, 8'h42, 8'h5A);
    wait_idle(400);
    compare(start, "fifo", 1'b1);
  endtask

  task automatic test_timeout();
    int start = got_q.size();
    int start2;
    rx_len = 100;
    send(1'b0, 8'h30, 8'h55);
    wait_idle(400);
    checks++;
    if (got_q.size() < start + 2 || got_q[start+1].t - got_q[start].t != 12) begin
      failures++;
      $display("FAIL timeout_latency: strobes=%0d (gap not 12) required addr->data gap of 12 cycles",
               got_q.size() - start);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flag: timeout_err=%b required 1", timeout_err);
    end
    compare(start, "timeout", 1'b0);
    m_valid = 1'b0;
    rx_len  = 2;
    start2  = got_q.size();
    send(1'b0, 8'h30, 8'h66);
    wait_idle(400);
    compare(start2, "timeout_retry", 1'b1);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: timeout_err=%b required 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int start;
    int n = 0;
    reset_dut();
    rx_force_val = 1'b1;
    rx_force     = 1'b1;
    rx_len       = 50;
    @(negedge clk);
    start = got_q.size();
    send(1'b0, 8'h50, 8'h01);
    send(1'b1, 8'h51, 8'h02);
    send(1'b0, 8'h52, 8'h03);
    rx_force = 1'b0;
    while (got_q.size() == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (got_q.size() == start) begin
      failures++;
      $display("FAIL rstmid_start: no address strobe within %0d cycles, required one", n);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    m_valid = 1'b0;
    exp_q.delete();
    start = got_q.size();
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() != start) begin
      failures++;
      $display("FAIL rstmid_strobe: strobes after reset=%0d required 0", got_q.size() - start);
    end
    checks++;
    if (idle !== 1'b1 || cmd_ready !== 1'b1 || write !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state: idle=%b cmd_ready=%b write=%b timeout_err=%b required 1/1/0/0",
               idle, cmd_ready, write, timeout_err);
    end
  endtask

  task automatic test_random();
    int start = got_q.size();
    rx_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send(1'($urandom_range(1, 0)), 8'h20 + 8'($urandom_range(3, 0)), 8'($urandom));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_idle(3000);
    compare(start, "random", 1'b1);
    rx_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_cache_hit();
    test_port_differs();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
